// File: rtl/rv32i_types.sv
// Shared types for the execute-side issue logic.
//   mul_state_t     : multiplier occupancy FSM states
//   DEF_NUM_REQ     : default number of reservation-station entries
//   DEF_NUM_ALU     : default number of single-cycle ALU lanes
//   DEF_MUL_LATENCY : default cycles from mul_start to mul_wb_valid
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam int unsigned DEF_NUM_REQ     = 8;
  localparam int unsigned DEF_NUM_ALU     = 2;
  localparam int unsigned DEF_MUL_LATENCY = 4;

endpackage

// File: rtl/rr_pick_n.sv
// Round-robin picker: returns the first N set bits of req in scan order
// ptr, ptr+1, ... NUM_REQ-1, 0, ... ptr-1.
//   req        : request vector
//   ptr        : scan start position
//   pick_valid : slot k holds a pick
//   pick_idx   : entry index of slot k (0 when slot unused)
//   pick_off   : scan offset (distance from ptr) of slot k (0 when unused)
//   grant      : one-hot-per-pick mask of picked entries
module rr_pick_n #(
  parameter int unsigned NUM_REQ = 8,
  parameter int unsigned N       = 1,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [N-1:0]       pick_valid,
  output logic [N*IDX_W-1:0] pick_idx,
  output logic [N*IDX_W-1:0] pick_off,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    int unsigned taken;
    int unsigned pos;
    pick_valid = '0;
    pick_idx   = '0;
    pick_off   = '0;
    grant      = '0;
    taken      = 0;
    pos        = 0;
    // Walking offsets in increasing order is the rotate step; the first
    // hits along that walk are the priority-encoded picks.
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      pos = 32'(ptr) + j;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (req[pos] && taken < N) begin
        pick_valid[taken]                 = 1'b1;
        pick_idx[taken*IDX_W +: IDX_W]    = IDX_W'(pos);
        pick_off[taken*IDX_W +: IDX_W]    = IDX_W'(j);
        grant[pos]                        = 1'b1;
        taken                             = taken + 1;
      end
    end
  end

endmodule

// File: rtl/fu_issue_scheduler.sv
// Issue scheduler between reservation-station entries and execute units.
// Picks ready entries round-robin onto NUM_ALU single-cycle ALU lanes and
// one shared unpipelined multiplier; sequences the multiplier result onto
// a valid/ready writeback port. Emits entry indices only.
//   clk, rst (async, active-low), flush (sync squash)
//   req_valid/req_is_mul : per-entry ready and unit type
//   req_grant            : per-entry issue this cycle
//   alu_start/alu_sel    : per-lane start and entry index
//   mul_start/mul_sel    : multiplier accept and entry index
//   mul_busy             : multiplier occupied
//   mul_wb_valid/ready   : multiplier result handshake
module fu_issue_scheduler
  import rv32i_types::*;
#(
  parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
  parameter int unsigned NUM_ALU     = DEF_NUM_ALU,
  parameter int unsigned MUL_LATENCY = DEF_MUL_LATENCY,
  parameter int unsigned IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_is_mul,
  output logic [NUM_REQ-1:0]       req_grant,
  output logic [NUM_ALU-1:0]       alu_start,
  output logic [NUM_ALU*IDX_W-1:0] alu_sel,
  output logic                     mul_start,
  output logic [IDX_W-1:0]         mul_sel,
  output logic                     mul_busy,
  output logic                     mul_wb_valid,
  input  logic                     mul_wb_ready
);

  localparam int unsigned CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  mul_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0]       alu_req, mul_req;
  logic [NUM_ALU-1:0]       alu_v;
  logic [NUM_ALU*IDX_W-1:0] alu_idx, alu_off;
  logic [NUM_REQ-1:0]       alu_gnt;
  logic [0:0]               mul_v;
  logic [IDX_W-1:0]         mul_idx, mul_off;
  logic [NUM_REQ-1:0]       mul_gnt;

  logic live, mul_accept, mul_fire, any_grant;
  logic [IDX_W-1:0] last_off;

  assign alu_req = req_valid & ~req_is_mul;
  assign mul_req = req_valid &  req_is_mul;

  rr_pick_n #(.NUM_REQ(NUM_REQ), .N(NUM_ALU), .IDX_W(IDX_W)) u_alu_pick (
    .req        (alu_req),
    .ptr        (rr_ptr_q),
    .pick_valid (alu_v),
    .pick_idx   (alu_idx),
    .pick_off   (alu_off),
    .grant      (alu_gnt)
  );

  rr_pick_n #(.NUM_REQ(NUM_REQ), .N(1), .IDX_W(IDX_W)) u_mul_pick (
    .req        (mul_req),
    .ptr        (rr_ptr_q),
    .pick_valid (mul_v),
    .pick_idx   (mul_idx),
    .pick_off   (mul_off),
    .grant      (mul_gnt)
  );

  // Gating with rst keeps every output low during an asynchronous reset,
  // including the purely combinational grant paths.
  assign live       = rst & ~flush;
  assign mul_accept = (state_q == IDLE) || (state_q == DONE && mul_wb_ready);
  assign mul_fire   = live & mul_v[0] & mul_accept;

  assign alu_start    = live ? alu_v   : '0;
  assign alu_sel      = live ? alu_idx : '0;
  assign mul_start    = mul_fire;
  assign mul_sel      = mul_fire ? mul_idx : '0;
  assign req_grant    = live ? (alu_gnt | (mul_fire ? mul_gnt : '0)) : '0;
  assign mul_busy     = rst & (state_q != IDLE);
  assign mul_wb_valid = live & (state_q == DONE);

  // ALU picks arrive in increasing scan offset, so the last active lane
  // carries the largest ALU offset; the multiplier offset is merged in.
  always_comb begin
    int unsigned sum;
    last_off  = '0;
    any_grant = 1'b0;
    sum       = 0;
    for (int unsigned k = 0; k < NUM_ALU; k++) begin
      if (alu_start[k]) begin
        last_off  = alu_off[k*IDX_W +: IDX_W];
        any_grant = 1'b1;
      end
    end
    if (mul_fire) begin
      any_grant = 1'b1;
      if (mul_off > last_off) last_off = mul_off;
    end
    sum = 32'(rr_ptr_q) + 32'(last_off) + 1;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    rr_ptr_d = any_grant ? IDX_W'(sum) : rr_ptr_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mul_fire) begin
          state_d = (MUL_LATENCY == 1) ? DONE : BUSY;
          cnt_d   = CNT_W'(MUL_LATENCY - 1);
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (mul_wb_ready) begin
          if (mul_fire) begin
            state_d = (MUL_LATENCY == 1) ? DONE : BUSY;
            cnt_d   = CNT_W'(MUL_LATENCY - 1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_fu_issue_scheduler.sv
module tb_fu_issue_scheduler;

  localparam int NR  = 8;
  localparam int NA  = 2;
  localparam int LAT = 4;
  localparam int IW  = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic [NR-1:0]  req_valid, req_is_mul, req_grant;
  logic [NA-1:0]  alu_start;
  logic [NA*IW-1:0] alu_sel;
  logic           mul_start;
  logic [IW-1:0]  mul_sel;
  logic           mul_busy, mul_wb_valid, mul_wb_ready;

  fu_issue_scheduler #(
    .NUM_REQ(NR), .NUM_ALU(NA), .MUL_LATENCY(LAT), .IDX_W(IW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_is_mul(req_is_mul), .req_grant(req_grant),
    .alu_start(alu_start), .alu_sel(alu_sel),
    .mul_start(mul_start), .mul_sel(mul_sel),
    .mul_busy(mul_busy), .mul_wb_valid(mul_wb_valid), .mul_wb_ready(mul_wb_ready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: pointer as an integer, multiplier as "operation in
  // flight, started age cycles ago".
  int m_ptr;
  bit m_active;
  int m_age;

  logic [NR-1:0]    e_grant;
  logic [NA-1:0]    e_alu_start;
  logic [NA*IW-1:0] e_alu_sel;
  logic             e_mul_start;
  logic [IW-1:0]    e_mul_sel;
  logic             e_busy, e_wbv;
  int               e_last;
  bit               e_any;

  logic [NR-1:0]    o_grant;
  logic [NA*IW-1:0] o_alu_sel;
  logic             o_mul_start, o_busy, o_wbv;
  logic [IW-1:0]    o_mul_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_comb();
    int lanes;
    int i;
    bit accept, res_ready;
    e_grant = '0; e_alu_start = '0; e_alu_sel = '0;
    e_mul_start = 1'b0; e_mul_sel = '0; e_last = 0; e_any = 1'b0;
    res_ready = m_active && (m_age >= LAT);
    e_busy = rst && m_active;
    e_wbv  = rst && res_ready && !flush;
    if (!rst || flush) return;
    accept = !m_active || (res_ready && mul_wb_ready);
    lanes = 0;
    for (int j = 0; j < NR; j++) begin
      i = (m_ptr + j) % NR;
      if (req_valid[i] && !req_is_mul[i] && lanes < NA) begin
        e_grant[i] = 1'b1;
        e_alu_start[lanes] = 1'b1;
        e_alu_sel[lanes*IW +: IW] = IW'(i);
        lanes++;
        e_last = j; e_any = 1'b1;
      end else if (req_valid[i] && req_is_mul[i] && accept && !e_mul_start) begin
        e_grant[i] = 1'b1;
        e_mul_start = 1'b1;
        e_mul_sel = IW'(i);
        e_last = j; e_any = 1'b1;
      end
    end
  endtask

  task automatic model_seq();
    if (!rst) begin
      m_ptr = 0; m_active = 0; m_age = 0;
      return;
    end
    if (flush) m_active = 0;
    else if (e_mul_start) begin m_active = 1; m_age = 1; end
    else if (m_active && m_age >= LAT && mul_wb_ready) m_active = 0;
    else if (m_active) m_age++;
    if (e_any) m_ptr = (m_ptr + e_last + 1) % NR;
  endtask

  // One cycle: drive at posedge+1, check at posedge+4, advance the model.
  task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] m,
                      input logic rdy, input logic fl);
    req_valid = v; req_is_mul = m; mul_wb_ready = rdy; flush = fl;
    #3;
    model_comb();
    o_grant = req_grant; o_alu_sel = alu_sel; o_mul_start = mul_start;
    o_mul_sel = mul_sel; o_busy = mul_busy; o_wbv = mul_wb_valid;
    chk("req_grant",    32'(req_grant),    32'(e_grant));
    chk("alu_start",    32'(alu_start),    32'(e_alu_start));
    chk("alu_sel",      32'(alu_sel),      32'(e_alu_sel));
    chk("mul_start",    32'(mul_start),    32'(e_mul_start));
    chk("mul_sel",      32'(mul_sel),      32'(e_mul_sel));
    chk("mul_busy",     32'(mul_busy),     32'(e_busy));
    chk("mul_wb_valid", 32'(mul_wb_valid), 32'(e_wbv));
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"},  32'(req_grant),    32'd0);
    chk({tag, "_astart"}, 32'(alu_start),    32'd0);
    chk({tag, "_asel"},   32'(alu_sel),      32'd0);
    chk({tag, "_mstart"}, 32'(mul_start),    32'd0);
    chk({tag, "_msel"},   32'(mul_sel),      32'd0);
    chk({tag, "_busy"},   32'(mul_busy),     32'd0);
    chk({tag, "_wbv"},    32'(mul_wb_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [NR-1:0] pv, pm;
    logic rdy, fl;
    rst = 1'b0; flush = 1'b0; mul_wb_ready = 1'b1;
    req_valid = 8'hFF; req_is_mul = 8'h0F;
    m_ptr = 0; m_active = 0; m_age = 0;
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // Scan from 0: entries 0 and 2 on lanes 0/1
    step(8'b00101101, 8'h00, 1'b1, 1'b0);
    chk("t1_grant", 32'(o_grant), 32'h05);
    chk("t1_sel",   32'(o_alu_sel), 32'({3'd2, 3'd0}));
    // Pointer now 3: entries 3 and 5
    step(8'b00101000, 8'h00, 1'b1, 1'b0);
    chk("t1_ptr3", 32'(o_grant), 32'h28);
    // Pointer 6: entries 6 and 7, pointer wraps to 0
    step(8'b11000011, 8'h00, 1'b1, 1'b0);
    chk("t2_grant", 32'(o_grant), 32'hC0);
    step(8'b10000011, 8'h00, 1'b1, 1'b0);
    chk("t2_wrap",  32'(o_grant), 32'h03);

    // Multiplier at entry 4, second mul blocked, back-to-back at t+4
    step(8'h10, 8'h10, 1'b1, 1'b0);
    chk("t3_mstart", 32'(o_mul_start), 32'd1);
    chk("t3_msel",   32'(o_mul_sel),   32'd4);
    step(8'h40, 8'h40, 1'b1, 1'b0);
    chk("t3_busy1",  32'(o_busy),      32'd1);
    chk("t3_block1", 32'(o_mul_start), 32'd0);
    step(8'h40, 8'h40, 1'b1, 1'b0);
    step(8'h40, 8'h40, 1'b1, 1'b0);
    chk("t3_nowbv3", 32'(o_wbv),       32'd0);
    step(8'h40, 8'h40, 1'b1, 1'b0);
    chk("t3_wbv4",   32'(o_wbv),       32'd1);
    chk("t3_b2b",    32'(o_mul_start), 32'd1);
    chk("t3_b2bsel", 32'(o_mul_sel),   32'd6);

    // Backpressure in DONE
    repeat (3) step(8'h00, 8'h00, 1'b1, 1'b0);
    repeat (3) begin
      step(8'h02, 8'h02, 1'b0, 1'b0);
      chk("t4_hold_wbv", 32'(o_wbv),       32'd1);
      chk("t4_no_grant", 32'(o_mul_start), 32'd0);
    end
    step(8'h00, 8'h00, 1'b1, 1'b0);
    chk("t4_consume", 32'(o_wbv), 32'd1);
    step(8'h00, 8'h00, 1'b1, 1'b0);
    chk("t4_idle",    32'(o_busy), 32'd0);

    // Flush during BUSY
    step(8'h01, 8'h01, 1'b1, 1'b0);
    step(8'h00, 8'h00, 1'b1, 1'b0);
    step(8'h0C, 8'h00, 1'b1, 1'b1);
    chk("t5_flush_grant", 32'(o_grant), 32'd0);
    step(8'h03, 8'h00, 1'b1, 1'b0);
    chk("t5_idle",    32'(o_busy),    32'd0);
    chk("t5_ptrheld", 32'(o_alu_sel), 32'({3'd0, 3'd1}));
    repeat (4) begin
      step(8'h00, 8'h00, 1'b1, 1'b0);
      chk("t5_no_wbv", 32'(o_wbv), 32'd0);
    end

    // Asynchronous reset mid-BUSY
    step(8'h20, 8'h20, 1'b1, 1'b0);
    step(8'h00, 8'h00, 1'b1, 1'b0);
    req_valid = 8'h0F; req_is_mul = 8'h00; rst = 1'b0;
    #1;
    chk_all_zero("t6_rst");
    m_ptr = 0; m_active = 0; m_age = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    step(8'h04, 8'h04, 1'b1, 1'b0);
    chk("t6_mstart", 32'(o_mul_start), 32'd1);
    chk("t6_msel",   32'(o_mul_sel),   32'd2);

    // Randomized traffic against the model
    pv = '0; pm = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pv[i] && $urandom_range(2) == 0) begin
          pv[i] = 1'b1;
          pm[i] = ($urandom_range(3) == 0);
        end
      end
      fl  = ($urandom_range(24) == 0);
      rdy = ($urandom_range(3) != 0);
      step(pv, pm, rdy, fl);
      pv = pv & ~e_grant;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
